// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmit FSM states, command bytes and frame geometry.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_START,
        ST_SHIFT,
        ST_ACK,
        ST_WAIT_IDLE
    } ps2_state_e;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_ACK         = 8'hFA;

    // Falling edges after clock release: 10 present d0..d7/parity/stop, the 11th samples ack.
    localparam int unsigned PS2_FRAME_EDGES = 11;
    localparam int unsigned PS2_STOP_IDX    = PS2_FRAME_EDGES - 2;

    function automatic logic [8:0] ps2_frame(input logic [7:0] data);
        return {~^data, data};
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop pad synchronizer with registered level and falling-edge pulse (idle-high line).
module ps2_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pad_i,
    output logic level_o,
    output logic fall_o
);

    logic sync1_q, sync2_q, level_q, fall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= pad_i;
            sync2_q <= sync1_q;
            level_q <= sync2_q;
            fall_q  <= level_q & ~sync2_q;
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, bit shifting, ack and watchdog.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clock_in,
    input  logic       ps2_data_in,
    output logic       ps2_clock_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_nack,
    output logic       tx_timeout
);

    localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       STOP_IDX = 4'(PS2_STOP_IDX);

    ps2_state_e       state_q, state_d;
    logic [8:0]       frame_q, frame_d;
    logic [INH_W-1:0] inh_q, inh_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic [3:0]       idx_q, idx_d;
    logic             ack_ok_q, ack_ok_d;
    logic             clock_oe_q, clock_oe_d, data_oe_q, data_oe_d;
    logic             ready_q, ready_d, busy_q, busy_d;
    logic             done_q, done_d, nack_q, nack_d, tout_q, tout_d;

    logic clk_level, clk_fall, dat_level, dat_fall_unused;
    logic wd_active, wd_expire;

    ps2_sync_edge u_sync_clk (
        .clk_i  (clock),
        .rst_ni (resetn),
        .pad_i  (ps2_clock_in),
        .level_o(clk_level),
        .fall_o (clk_fall)
    );

    ps2_sync_edge u_sync_dat (
        .clk_i  (clock),
        .rst_ni (resetn),
        .pad_i  (ps2_data_in),
        .level_o(dat_level),
        .fall_o (dat_fall_unused)
    );

    assign wd_active = state_q inside {ST_START, ST_SHIFT, ST_ACK, ST_WAIT_IDLE};
    assign wd_expire = wd_active && (wd_q == WD_LAST);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            frame_q    <= '0;
            inh_q      <= '0;
            wd_q       <= '0;
            idx_q      <= '0;
            ack_ok_q   <= 1'b0;
            clock_oe_q <= 1'b0;
            data_oe_q  <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            nack_q     <= 1'b0;
            tout_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            inh_q      <= inh_d;
            wd_q       <= wd_d;
            idx_q      <= idx_d;
            ack_ok_q   <= ack_ok_d;
            clock_oe_q <= clock_oe_d;
            data_oe_q  <= data_oe_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            nack_q     <= nack_d;
            tout_q     <= tout_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        frame_d  = frame_q;
        inh_d    = inh_q;
        wd_d     = wd_active ? wd_q + 1'b1 : wd_q;
        idx_d    = idx_q;
        ack_ok_d = ack_ok_q;
        unique case (state_q)
            ST_IDLE: if (tx_valid && ready_q) begin
                frame_d = ps2_frame(tx_data);
                inh_d   = '0;
                state_d = ST_INHIBIT;
            end
            ST_INHIBIT: if (inh_q == INH_LAST) begin
                state_d = ST_START;
                wd_d    = '0;
                idx_d   = '0;
            end else begin
                inh_d = inh_q + 1'b1;
            end
            ST_START: if (clk_fall) begin
                state_d = ST_SHIFT;
                idx_d   = 4'd1;
            end
            ST_SHIFT: if (clk_fall) begin
                if (idx_q == STOP_IDX) state_d = ST_ACK;
                else                   idx_d   = idx_q + 1'b1;
            end
            ST_ACK: if (clk_fall) begin
                ack_ok_d = ~dat_level;
                state_d  = ST_WAIT_IDLE;
            end
            ST_WAIT_IDLE: if (clk_level && dat_level) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (wd_expire) state_d = ST_IDLE;
    end

    // Outputs are decoded from the next state so every pin comes straight from a flop.
    always_comb begin
        clock_oe_d = (state_d == ST_INHIBIT);
        ready_d    = (state_d == ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
        tout_d     = wd_expire;
        done_d     = 1'b0;
        nack_d     = 1'b0;
        unique case (state_d)
            ST_INHIBIT: data_oe_d = (inh_d == INH_LAST);
            ST_START:   data_oe_d = 1'b1;
            ST_SHIFT:   data_oe_d = clk_fall ? ~frame_q[idx_q] : data_oe_q;
            default:    data_oe_d = 1'b0;
        endcase
        if (state_q == ST_WAIT_IDLE && state_d == ST_IDLE && !wd_expire) begin
            done_d = ack_ok_q;
            nack_d = ~ack_ok_q;
        end
    end

    assign tx_ready     = ready_q;
    assign busy         = busy_q;
    assign ps2_clock_oe = clock_oe_q;
    assign ps2_data_oe  = data_oe_q;
    assign tx_done      = done_q;
    assign tx_nack      = nack_q;
    assign tx_timeout   = tout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with an open-drain device model on the PS/2 pair.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int unsigned INH = 5000;
    localparam int unsigned TO  = 2000;
    localparam int unsigned H   = 30;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ps2_clock_oe, ps2_data_oe, busy, tx_done, tx_nack, tx_timeout;
    logic       dev_clk_low = 1'b0, dev_dat_low = 1'b0;
    logic       ps2_clock_in, ps2_data_in;

    assign ps2_clock_in = ~(ps2_clock_oe | dev_clk_low);
    assign ps2_data_in  = ~(ps2_data_oe | dev_dat_low);

    int cyc = 0;
    int n_checks = 0;
    int n_err = 0;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .resetn(resetn), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .ps2_clock_in(ps2_clock_in), .ps2_data_in(ps2_data_in),
        .ps2_clock_oe(ps2_clock_oe), .ps2_data_oe(ps2_data_oe), .busy(busy),
        .tx_done(tx_done), .tx_nack(tx_nack), .tx_timeout(tx_timeout)
    );

    always #10 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bits as the device should see them, in wire order: d0..d7, odd parity, stop.
    function automatic logic [9:0] model_bits(input logic [7:0] b);
        logic [9:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[i];
        r[8] = ($countones(b) % 2 == 0);
        r[9] = 1'b1;
        return r;
    endfunction

    task automatic send_req(input logic [7:0] b);
        int w = 0;
        while (!tx_ready && w < 1000) begin @(negedge clock); w++; end
        chk("ready_before_req", tx_ready, 1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
        chk("accept_ready_low", tx_ready, 0);
        chk("accept_busy", busy, 1);
        chk("accept_clock_oe", ps2_clock_oe, 1);
    endtask

    task automatic measure_inhibit(input string tag);
        int   n = 0;
        logic prev_d = 1'b0, last_d = 1'b0;
        while (ps2_clock_oe && n < int'(INH) + 10) begin
            prev_d = last_d;
            last_d = ps2_data_oe;
            n++;
            @(negedge clock);
        end
        chk({tag, "_inhibit_len"}, n, INH);
        chk({tag, "_start_bit_last"}, last_d, 1);
        chk({tag, "_start_bit_not_early"}, prev_d, 0);
        chk({tag, "_start_held_after_release"}, ps2_data_oe, 1);
    endtask

    task automatic dev_frame(input logic ack_low, output logic [9:0] bits);
        for (int i = 0; i < 10; i++) begin
            repeat (H) @(negedge clock);
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clock);
            dev_clk_low = 1'b0;
            bits[i] = ps2_data_in;
        end
        repeat (H / 2) @(negedge clock);
        if (ack_low) dev_dat_low = 1'b1;
        repeat (H / 2) @(negedge clock);
        dev_clk_low = 1'b1;
        repeat (H) @(negedge clock);
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
    endtask

    task automatic wait_result(input int bound, output logic seen, output logic d,
                               output logic n, output logic t, output int at);
        seen = 1'b0; d = 1'b0; n = 1'b0; t = 1'b0; at = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clock);
            if (tx_done || tx_nack || tx_timeout) begin
                seen = 1'b1; d = tx_done; n = tx_nack; t = tx_timeout; at = cyc;
            end
        end
    endtask

    task automatic check_result(input string tag, input logic ack_low);
        logic seen, d, n, t;
        int   at;
        wait_result(300, seen, d, n, t, at);
        chk({tag, "_result_seen"}, seen, 1);
        chk({tag, "_done"}, d, ack_low);
        chk({tag, "_nack"}, n, !ack_low);
        chk({tag, "_no_timeout"}, t, 0);
        chk({tag, "_ready_with_result"}, tx_ready, 1);
        @(negedge clock);
        chk({tag, "_pulse_one_cycle"}, {tx_done, tx_nack}, 0);
        chk({tag, "_lines_released"}, {ps2_clock_oe, ps2_data_oe}, 0);
    endtask

    task automatic do_frame(input string tag, input logic [7:0] b, input logic ack_low,
                            output logic [9:0] bits);
        send_req(b);
        measure_inhibit(tag);
        dev_frame(ack_low, bits);
        chk({tag, "_bits"}, bits, model_bits(b));
        check_result(tag, ack_low);
    endtask

    initial begin
        #5ms;
        $display("FAIL global_time_limit: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [9:0] bits;
        logic       seen, d, n, t;
        int         at, rel, pulses;
        logic [7:0] rb;
        logic       rack;

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_ready", tx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_oe", {ps2_clock_oe, ps2_data_oe}, 0);
        chk("rst_pulses", {tx_done, tx_nack, tx_timeout}, 0);
        resetn = 1'b1;
        repeat (3) @(negedge clock);

        // Reset in the middle of SHIFT
        send_req(8'h00);
        measure_inhibit("rstmid");
        for (int i = 0; i < 3; i++) begin
            repeat (H) @(negedge clock);
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clock);
            dev_clk_low = 1'b0;
        end
        chk("rstmid_pre_data_oe", ps2_data_oe, 1);
        chk("rstmid_pre_busy", busy, 1);
        #3 resetn = 1'b0;
        #1;
        chk("rstmid_oe_async", {ps2_clock_oe, ps2_data_oe}, 0);
        chk("rstmid_busy_async", busy, 0);
        repeat (5) @(negedge clock);
        resetn = 1'b1;
        pulses = 0;
        repeat (200) begin
            @(negedge clock);
            if (tx_done || tx_nack || tx_timeout) pulses++;
        end
        chk("rstmid_no_result", pulses, 0);
        chk("rstmid_ready_after", tx_ready, 1);

        // Normal frame 0xED acked, with explicit wire pattern
        do_frame("ed", PS2_CMD_SET_LED, 1'b1, bits);
        chk("ed_wire_pattern", bits, 10'b11_1110_1101);

        // 0xF4: parity bit 0
        do_frame("f4", PS2_CMD_ENABLE, 1'b1, bits);
        chk("f4_parity", bits[8], 0);

        // Nack: device leaves data high at edge 11
        do_frame("nack", PS2_ACK, 1'b0, bits);

        // Silent device: watchdog from clock release
        send_req(PS2_CMD_RESET);
        measure_inhibit("silent");
        rel = cyc;
        wait_result(int'(TO) + 50, seen, d, n, t, at);
        chk("silent_seen", seen, 1);
        chk("silent_timeout", t, 1);
        chk("silent_no_done_nack", {d, n}, 0);
        chk("silent_latency", at - rel, TO);
        chk("silent_lines_released", {ps2_clock_oe, ps2_data_oe}, 0);
        chk("silent_idle", {tx_ready, busy}, 2'b10);
        @(negedge clock);
        chk("silent_pulse_one_cycle", tx_timeout, 0);

        // Back-to-back with tx_valid held: second accepted only after first done
        while (!tx_ready) @(negedge clock);
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(negedge clock);
        chk("b2b_first_accept", ps2_clock_oe, 1);
        tx_data = 8'hFF;
        measure_inhibit("b2b0");
        dev_frame(1'b1, bits);
        chk("b2b0_bits", bits, model_bits(8'h00));
        chk("b2b0_parity", bits[8], 1);
        chk("b2b0_still_busy", {tx_ready, busy}, 2'b01);
        wait_result(300, seen, d, n, t, at);
        chk("b2b0_done", {seen, d, n, t}, 4'b1100);
        chk("b2b0_ready_with_done", tx_ready, 1);
        chk("b2b0_clock_free_at_done", ps2_clock_oe, 0);
        @(negedge clock);
        chk("b2b_second_accept", {ps2_clock_oe, tx_ready}, 2'b10);
        tx_valid = 1'b0;
        measure_inhibit("b2b1");
        dev_frame(1'b1, bits);
        chk("b2b1_bits", bits, model_bits(8'hFF));
        check_result("b2b1", 1'b1);

        // Randomized commands and ack/nack responses
        for (int r = 0; r < 3; r++) begin
            rb   = 8'($urandom);
            rack = 1'($urandom_range(0, 1));
            do_frame("rand", rb, rack, bits);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
